// File: rtl/hfnc_pipe.sv
// rtl/hfnc_pipe.sv - pipelined SHA-256/512 round-function unit (Ch/Maj/Parity/ADD3/Sigma)
// Valid/ready on both sides; STAGES slots, each holding valid, data word and opcode.
module hfnc_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       out_op
);

  if (!((WIDTH == 32 || WIDTH == 64) && (STAGES == 1 || STAGES == 2))) begin : gBadParam
    $error("hfnc_pipe: WIDTH must be 32 or 64 and STAGES must be 1 or 2");
  end

  localparam bit W64  = (WIDTH == 64);
  localparam int BS0A = W64 ? 28 : 2;
  localparam int BS0B = W64 ? 34 : 13;
  localparam int BS0C = W64 ? 39 : 22;
  localparam int BS1A = W64 ? 14 : 6;
  localparam int BS1B = W64 ? 18 : 11;
  localparam int BS1C = W64 ? 41 : 25;
  localparam int SS0A = W64 ? 1  : 7;
  localparam int SS0B = W64 ? 8  : 18;
  localparam int SS0C = W64 ? 7  : 3;
  localparam int SS1A = W64 ? 19 : 17;
  localparam int SS1B = W64 ? 61 : 19;
  localparam int SS1C = W64 ? 6  : 10;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input int n);
    return (v >> n) | (v << (WIDTH - n));
  endfunction

  logic [WIDTH-1:0] csSum, csCarry, logicRes, s0In;
  logic [WIDTH-1:0] s0Data, s0Carry;
  logic [2:0]       s0Op;
  logic             s0Valid, s0Adv, accept;

  // ADD3 is split into a carry-save pair so the full adder sits in the stage after slot 0.
  always_comb begin
    csSum    = x ^ y ^ z;
    csCarry  = ((x & y) | (x & z) | (y & z)) << 1;
    logicRes = csSum;
    case (op)
      3'd0: logicRes = (x & y) ^ (~x & z);
      3'd1: logicRes = (x & y) ^ (x & z) ^ (y & z);
      3'd2: logicRes = csSum;
      3'd3: logicRes = csSum;
      3'd4: logicRes = rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
      3'd5: logicRes = rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
      3'd6: logicRes = rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
      3'd7: logicRes = rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
      default: logicRes = csSum;
    endcase
    s0In = (STAGES == 1 && op == 3'd3) ? csSum + csCarry : logicRes;
  end

  assign in_ready = !s0Valid || s0Adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0Valid <= 1'b0;
      s0Data  <= '0;
      s0Carry <= '0;
      s0Op    <= 3'd0;
    end else if (accept) begin
      s0Valid <= 1'b1;
      s0Data  <= s0In;
      s0Carry <= csCarry;
      s0Op    <= op;
    end else if (s0Adv) begin
      s0Valid <= 1'b0;
    end
  end

  if (STAGES == 1) begin : gOne
    assign s0Adv     = s0Valid && out_ready;
    assign out_valid = s0Valid;
    assign result    = s0Data;
    assign out_op    = s0Op;
  end else begin : gTwo
    logic             s1Valid;
    logic [WIDTH-1:0] s1Data;
    logic [2:0]       s1Op;

    assign s0Adv = s0Valid && (!s1Valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1Valid <= 1'b0;
        s1Data  <= '0;
        s1Op    <= 3'd0;
      end else if (s0Adv) begin
        s1Valid <= 1'b1;
        s1Data  <= (s0Op == 3'd3) ? s0Data + s0Carry : s0Data;
        s1Op    <= s0Op;
      end else if (s1Valid && out_ready) begin
        s1Valid <= 1'b0;
      end
    end

    assign out_valid = s1Valid;
    assign result    = s1Data;
    assign out_op    = s1Op;
  end

endmodule

// File: tb/tb_hfnc_pipe.sv
// tb/tb_hfnc_pipe.sv - directed self-checking bench for hfnc_pipe
// Instance A: WIDTH=32 STAGES=2; instance B: WIDTH=64 STAGES=1.
module tb_hfnc_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        aInValid, aInReady, aOutValid, aOutReady;
  logic [2:0]  aOp, aOutOp;
  logic [31:0] aX, aY, aZ, aResult;

  logic        bInValid, bInReady, bOutValid, bOutReady;
  logic [2:0]  bOp, bOutOp;
  logic [63:0] bX, bY, bZ, bResult;

  int checks = 0;
  int failures = 0;

  hfnc_pipe #(.WIDTH(32), .STAGES(2)) dutA (
    .clk(clk), .rst(rst), .in_valid(aInValid), .in_ready(aInReady), .op(aOp),
    .x(aX), .y(aY), .z(aZ), .out_valid(aOutValid), .out_ready(aOutReady),
    .result(aResult), .out_op(aOutOp)
  );

  hfnc_pipe #(.WIDTH(64), .STAGES(1)) dutB (
    .clk(clk), .rst(rst), .in_valid(bInValid), .in_ready(bInReady), .op(bOp),
    .x(bX), .y(bY), .z(bZ), .out_valid(bOutValid), .out_ready(bOutReady),
    .result(bResult), .out_op(bOutOp)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; result expected two edges after acceptance.
  task automatic runA(input string tag, input logic [2:0] o, input logic [31:0] xx,
                      input logic [31:0] yy, input logic [31:0] zz, input logic [31:0] exp);
    aOp = o; aX = xx; aY = yy; aZ = zz; aInValid = 1'b1;
    #1 checkVal({tag, "_rdy"}, {63'd0, aInReady}, 64'd1);
    @(negedge clk);
    aInValid = 1'b0;
    checkVal({tag, "_lat"}, {63'd0, aOutValid}, 64'd0);
    @(negedge clk);
    checkVal({tag, "_vld"}, {63'd0, aOutValid}, 64'd1);
    checkVal({tag, "_res"}, {32'd0, aResult}, {32'd0, exp});
    checkVal({tag, "_op"}, {61'd0, aOutOp}, {61'd0, o});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    aInValid = 1'b0; aOp = 3'd0; aX = '0; aY = '0; aZ = '0; aOutReady = 1'b1;
    bInValid = 1'b0; bOp = 3'd0; bX = '0; bY = '0; bZ = '0; bOutReady = 1'b1;
    #12;
    checkVal("rstA_vld", {63'd0, aOutValid}, 64'd0);
    checkVal("rstA_res", {32'd0, aResult}, 64'd0);
    checkVal("rstA_op", {61'd0, aOutOp}, 64'd0);
    checkVal("rstB_vld", {63'd0, bOutValid}, 64'd0);
    checkVal("rstB_res", bResult, 64'd0);
    rst = 1'b0;
    #1;
    checkVal("rstA_rdy", {63'd0, aInReady}, 64'd1);
    checkVal("rstB_rdy", {63'd0, bInReady}, 64'd1);
    @(negedge clk);

    runA("bsig0", 3'd4, 32'h6a09e667, 32'h0, 32'h0, 32'hce20b47e);
    runA("bsig1", 3'd5, 32'h510e527f, 32'h0, 32'h0, 32'h3587272b);
    runA("ch", 3'd0, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h1f85c98c);
    runA("maj", 3'd1, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'h3a6fe667);
    runA("ssig0", 3'd6, 32'h00000001, 32'h0, 32'h0, 32'h02004000);
    runA("add3", 3'd3, 32'hffffffff, 32'h1, 32'h1, 32'h00000001);
    runA("par", 3'd2, 32'hf0f0f0f0, 32'hff00ff00, 32'h0, 32'h0ff00ff0);

    // WIDTH=64, STAGES=1: one-cycle latency and single-slot capacity.
    bOp = 3'd6; bX = 64'd1; bY = '0; bZ = '0; bInValid = 1'b1; bOutReady = 1'b0;
    #1 checkVal("b_rdy", {63'd0, bInReady}, 64'd1);
    @(negedge clk);
    checkVal("b_vld", {63'd0, bOutValid}, 64'd1);
    checkVal("b_res", bResult, 64'h8100000000000000);
    bOp = 3'd2; bX = 64'd5;
    #1 checkVal("b_full", {63'd0, bInReady}, 64'd0);
    @(negedge clk);
    checkVal("b_hold", bResult, 64'h8100000000000000);
    bOutReady = 1'b1;
    #1 checkVal("b_rdyDrain", {63'd0, bInReady}, 64'd1);
    @(negedge clk);
    bInValid = 1'b0;
    checkVal("b_res2", bResult, 64'd5);
    checkVal("b_op2", {61'd0, bOutOp}, 64'd2);
    @(negedge clk);
    checkVal("b_empty", {63'd0, bOutValid}, 64'd0);

    // Backpressure on A: capacity 2, third accepted as first drains.
    aOutReady = 1'b0;
    aOp = 3'd2; aX = 32'hf0f0f0f0; aY = 32'hff00ff00; aZ = 32'h0; aInValid = 1'b1;
    #1 checkVal("bp_rdy1", {63'd0, aInReady}, 64'd1);
    @(negedge clk);
    aOp = 3'd3; aX = 32'hffffffff; aY = 32'h1; aZ = 32'h1;
    #1 checkVal("bp_rdy2", {63'd0, aInReady}, 64'd1);
    @(negedge clk);
    aOp = 3'd6; aX = 32'h1; aY = 32'h0; aZ = 32'h0;
    #1 checkVal("bp_rdy3", {63'd0, aInReady}, 64'd0);
    checkVal("bp_vld", {63'd0, aOutValid}, 64'd1);
    checkVal("bp_res1", {32'd0, aResult}, 64'h0ff00ff0);
    @(negedge clk);
    checkVal("bp_stillFull", {63'd0, aInReady}, 64'd0);
    checkVal("bp_stable", {32'd0, aResult}, 64'h0ff00ff0);
    checkVal("bp_stableOp", {61'd0, aOutOp}, 64'd2);
    aOutReady = 1'b1;
    #1 checkVal("bp_rdyComb", {63'd0, aInReady}, 64'd1);
    @(negedge clk);
    aInValid = 1'b0;
    checkVal("bp_res2", {32'd0, aResult}, 64'h1);
    checkVal("bp_op2", {61'd0, aOutOp}, 64'd3);
    @(negedge clk);
    checkVal("bp_res3", {32'd0, aResult}, 64'h02004000);
    checkVal("bp_op3", {61'd0, aOutOp}, 64'd6);
    @(negedge clk);
    checkVal("bp_empty", {63'd0, aOutValid}, 64'd0);

    // Streaming: item i uses op=i%4 with x=y=z=i+1, so Ch/Maj/Parity give i+1 and ADD3 gives 3(i+1).
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        aOp = 3'(c % 4); aX = 32'(c + 1); aY = 32'(c + 1); aZ = 32'(c + 1); aInValid = 1'b1;
      end else begin
        aInValid = 1'b0;
      end
      #1;
      if (c < 16) checkVal($sformatf("st_rdy%0d", c), {63'd0, aInReady}, 64'd1);
      if (c >= 2) begin
        checkVal($sformatf("st_vld%0d", c - 2), {63'd0, aOutValid}, 64'd1);
        checkVal($sformatf("st_res%0d", c - 2), {32'd0, aResult},
                 ((c - 2) % 4 == 3) ? 64'(3 * (c - 1)) : 64'(c - 1));
        checkVal($sformatf("st_op%0d", c - 2), {61'd0, aOutOp}, 64'((c - 2) % 4));
      end
      @(negedge clk);
    end
    checkVal("st_done", {63'd0, aOutValid}, 64'd0);

    // Asynchronous reset with two items in flight.
    aOutReady = 1'b0;
    aOp = 3'd2; aX = 32'h11; aY = 32'h0; aZ = 32'h0; aInValid = 1'b1;
    @(negedge clk);
    aOp = 3'd1; aX = 32'h22;
    @(negedge clk);
    aInValid = 1'b0;
    checkVal("ar_pre", {63'd0, aOutValid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    checkVal("ar_vld", {63'd0, aOutValid}, 64'd0);
    checkVal("ar_res", {32'd0, aResult}, 64'd0);
    checkVal("ar_op", {61'd0, aOutOp}, 64'd0);
    rst = 1'b0;
    #1 checkVal("ar_rdy", {63'd0, aInReady}, 64'd1);
    aOutReady = 1'b1;
    @(negedge clk);
    checkVal("ar_noStale1", {63'd0, aOutValid}, 64'd0);
    @(negedge clk);
    checkVal("ar_noStale2", {63'd0, aOutValid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hfnc_pipe.md
Name: hfnc_pipe

Overview:
- Parametrised, pipelined successor to the combinational SHA round-function unit.
- Computes Ch, Maj, Parity, a 3-input modular add, and the four SHA-2 Σ/σ functions for SHA-256 (WIDTH=32) or SHA-512 (WIDTH=64).
- Uses a valid/ready handshake on both sides, so it can sit between the hash controller's operand mux and the register-file writeback with backpressure.
- Every opcode is defined: no latch or hold behaviour on unused codes.

Parameters:
- WIDTH, 32, datapath width. Legal values are 32 (SHA-256 constants) and 64 (SHA-512 constants); any other value is an elaboration error.
- STAGES, 2, pipeline depth (equals latency in cycles). Legal values are 1 and 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operand set is presented.
- in_ready  out  1  the unit can accept the operand set this cycle.
- op  in  3  function select, encoded below.
- x  in  WIDTH  operand X.
- y  in  WIDTH  operand Y.
- z  in  WIDTH  operand Z.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  function result.
- out_op  out  3  opcode that produced result, carried through the pipeline for writeback steering.

Behaviour:
- Opcode encoding:
  - 0: Ch = (x&y)^(~x&z).
  - 1: Maj = (x&y)^(x&z)^(y&z).
  - 2: Parity = x^y^z.
  - 3: ADD3 = (x+y+z) mod 2^WIDTH; carries are discarded.
  - 4: Σ0.
  - 5: Σ1.
  - 6: σ0.
  - 7: σ1.
- Σ/σ for WIDTH=32 (ROTR = rotate right, SHR = logical shift right):
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22.
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25.
  - σ0 = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1 = ROTR17 ^ ROTR19 ^ SHR10.
- Σ/σ for WIDTH=64:
  - Σ0 = ROTR28 ^ ROTR34 ^ ROTR39.
  - Σ1 = ROTR14 ^ ROTR18 ^ ROTR41.
  - σ0 = ROTR1 ^ ROTR8 ^ SHR7.
  - σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- Opcodes 4–7 use x only; y and z are ignored.
- Pipeline structure: STAGES register slots. Each slot holds a valid bit, a WIDTH-bit data word and a 3-bit opcode.
  - Slot 0 captures when in_valid && in_ready.
  - The last slot drives result, out_op and out_valid.
- Stage split when STAGES=2:
  - Stage 0 registers the logic results and, for ADD3, a carry-save pair.
  - Stage 1 performs the final add and selects the result.
  - Only latency is externally observable.
- Advance rule: slot k advances into slot k+1 when slot k+1 is empty or is itself advancing. The last slot empties on out_valid && out_ready.
- in_ready = !slot0.valid || slot0 advancing. It is combinational from out_ready when every slot is full.
- Throughput: one result per cycle while out_ready=1.
- Latency: a result accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. it is observable in the cycle following edge N+STAGES−1.
- Result stability: while out_valid && !out_ready, result and out_op hold stable. No valid result is ever dropped or duplicated.
- Capacity: with out_ready held low, at most STAGES operand sets are accepted. in_ready then stays 0 until out_ready rises.
- Simultaneous accept and drain when all slots are full and out_ready=1: the pipeline shifts and the new operand is accepted in the same cycle.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - out_valid=0, all valid bits 0, result=0, out_op=0.
  - in_ready=1 as soon as rst deasserts.
  - In-flight data is discarded.
- Data registers need no reset beyond result and out_op, but must not produce X on result while out_valid=0.

Test Plan:
- SHA-256 round-1 vectors, WIDTH=32, STAGES=2, out_ready=1; each result appears 2 cycles after acceptance:
  - op=4, x=0x6a09e667 -> 0xce20b47e.
  - op=5, x=0x510e527f -> 0x3587272b.
  - op=0, x=0x510e527f, y=0x9b05688c, z=0x1f83d9ab -> 0x1f85c98c.
  - op=1, x=0x6a09e667, y=0xbb67ae85, z=0x3c6ef372 -> 0x3a6fe667.
- σ and wrap, WIDTH=32:
  - op=6, x=0x00000001 -> 0x02004000.
  - op=3, x=0xffffffff, y=1, z=1 -> 0x00000001 (carry discarded).
  - op=2, x=0xf0f0f0f0, y=0xff00ff00, z=0 -> 0x0ff00ff0.
- WIDTH=64, STAGES=1: op=6, x=1 -> 0x8100000000000000. Result appears 1 cycle after acceptance.
- Backpressure, STAGES=2:
  - Hold out_ready=0 and offer 3 back-to-back operands: only 2 are accepted, and in_ready=0 from the third cycle.
  - Raise out_ready: results emerge in order, result stays stable during the stall, and the third operand is accepted in the same cycle the first result drains.
- Streaming: 16 consecutive ops, with out_ready=1 and in_valid=1 throughout -> 16 results on 16 consecutive cycles, out_op matching input order.
- Reset mid-operation: assert rst asynchronously between edges with 2 items in flight -> out_valid drops to 0 immediately. After deassertion, in_ready=1 and no stale result appears.
